// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared state encoding and constants for instruction fetch
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OPC_B       = 6'b000101;
    localparam int         INSTR_BYTES = 4;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// rtl/instruction_fetch_fifo.sv - fetch_fifo: DEPTH x {pc,instr} buffer with flush
module fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [63:0]                push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [63:0]                head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [63:0]   hold_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Head stays at the last shown word while empty so decode sees stable values.
    assign head_data = empty ? hold_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            hold_q <= head_data;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, fetch FSM and branch predecode feeding the instruction buffer
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [31:0]   pc_q;
    logic [31:0]   pc_seq;
    logic [31:0]   b_offset;
    logic          fire;
    logic          pop;
    logic [63:0]   head_data;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          full;
    logic          empty;

    assign fire     = imem_req && imem_ack;
    assign pop      = if_valid && if_ready && !redirect;
    assign if_valid = !empty;
    assign if_instr = head_data[31:0];
    assign if_pc    = head_data[63:32];
    assign imem_addr = pc_q;

    // Predecode: unconditional B jumps straight to its target instead of PC+4.
    assign b_offset = {{4{imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
    assign pc_seq   = (imem_rdata[31:26] == OPC_B) ? pc_q + b_offset
                                                    : pc_q + 32'(INSTR_BYTES);

    always_comb begin
        count_nxt = count;
        if (redirect) begin
            count_nxt = '0;
        end else if (fire && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!fire && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    state_d = (count_nxt == CW'(DEPTH)) ? FULL : RUN;
                end
            end
            RUN, FULL: begin
                imem_req = (state_q == RUN) && !full && !redirect;
                if (!fetch_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = (count_nxt == CW'(DEPTH)) ? FULL : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (fire) begin
                pc_q <= pc_seq;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_data ({pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule
